inst_seq_ctrl: RTL and testbench
================================

// Module: inst_seq_ctrl
// PURPOSE
//  Multicycle instruction sequencer for the 16-bit GPR/flag datapath: owns PC and IR, fetches from instruction memory,
//  issues one execute strobe per instruction, resolves conditional jumps on sign/zero/carry/overflow, handles halt.
//  Sits between the instruction ROM and the ALU/GPR datapath inside top; the datapath executes only when exec_en=1.
// PARAMETERS
//  PC_W        5   PC/instruction-address width; PC wraps modulo 2**PC_W
//  IR_W        32  instruction width; field map per shared defines
//  DELAY_CYC   4   idle cycles between instructions (used only when SEQ_DELAY_EN defined); 0 legal
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  sys_rst    in   1     synchronous, active-high reset
//  start      in   1     level; leaves IDLE/HALT when 1, ignored elsewhere
//  imem_addr  out  PC_W  instruction address (= pc, combinational)
//  imem_data  in   IR_W  instruction word, combinational read of imem_addr
//  sign_f     in   1     datapath sign flag (registered in datapath)
//  zero_f     in   1     datapath zero flag
//  carry_f    in   1     datapath carry flag
//  ovf_f      in   1     datapath overflow flag
//  ir         out  IR_W  current instruction register, to datapath decode
//  exec_en    out  1     one-cycle execute strobe; datapath commits GPR/flags on the edge ending it
//  pc         out  PC_W  program counter
//  busy       out  1     1 in FETCH/EXEC/DELAY/NEXT
//  halted     out  1     1 in HALT
// BEHAVIOUR
//  Reset (sys_rst=1 at edge): state=IDLE, pc=0, ir=0, exec_en=0, halted=0, delay cnt=0; wins over every other event.
//  IDLE: start=1 -> FETCH else stay.
//  FETCH (1 cyc): ir <= imem_data -> EXEC.
//  EXEC (1 cyc): exec_en=1 (registered output, high exactly this cycle). Decode ir[31:27]:
//   jump: target = ir[PC_W-1:0]; taken always. jcarry/jnocarry, jsign/jnosign, jzero/jnozero, jovf/jnoovf:
//   taken iff flag input (value present during EXEC, i.e. result of previous ALU op) equals 1/0 respectively.
//   Not taken / non-jump: next_pc = pc+1 (mod 2**PC_W). Jump ops do not modify flags. halt: set halt_pend.
//   -> DELAY.
//  DELAY: see CONFIGURATION. -> NEXT.
//  NEXT (1 cyc): pc <= next_pc; halt_pend ? HALT : FETCH.
//  HALT: halted=1, pc already advanced past halt; start=1 -> FETCH (clears halt_pend, halted=0 next cycle).
//  Throughput without delay: 4 cycles/instruction (FETCH, EXEC, DELAY(0 cyc skipped->1 pass-through), NEXT) = 4 clk.
//  Boundaries: pc=2**PC_W-1 non-jump -> pc=0; jump to own address loops forever (legal);
//  start during busy ignored; reset mid-EXEC: exec_en deasserts on that edge, no further strobes until start.
//  Unknown opcodes: treated as non-jump, exec_en still pulses (datapath decides).
// CONFIGURATION
//  SEQ_DELAY_EN defined: DELAY holds DELAY_CYC cycles (counter loads 0, counts to DELAY_CYC-1; DELAY_CYC=0 -> 1 cycle),
//   giving 3+max(DELAY_CYC,1) cycles/instruction.
//  Undefined: DELAY is a single pass-through cycle, counter absent, DELAY_CYC ignored.
// STRUCTURE
//  Shared defines file (with datapath): IR field slices (`oper_type ir[31:27], `rdst, `rsrc1, `imm_mode, `rsrc2,
//   `isrc ir[15:0]), opcode constants (jump..halt), FSM state encodings.
//  Sub-module jump_cond_eval: combinational opcode+4 flags -> taken, is_halt; reused by later pipelined core.
// TESTING
//  1 Reset then start=1, imem 0..3 = add ops -> exec_en pulses every 4 clk, pc 0,1,2,3; ir matches imem.
//  2 zero_f=1, imem[2]=jzero target 9 -> pc 2->9; repeat with zero_f=0 -> pc 3.
//  3 carry_f=1, ovf_f=1 at jnocarry/jnoovf (target 7) -> not taken, pc+1; jcarry -> pc=7.
//  4 pc=31 (PC_W=5) non-jump -> pc=0; jump target 16'hFFE5 -> pc=5 (truncated).
//  5 imem[4]=halt -> halted=1, pc=5, no exec_en for 20 clk; start=1 -> fetch at 5.
//  6 sys_rst=1 during EXEC -> next edge pc=0, ir=0, exec_en=0, state IDLE; SEQ_DELAY_EN, DELAY_CYC=4 -> 7 clk/instr.

Source files
------------

// File: rtl/inst_seq_ctrl_pkg.sv
// Shared sequencer/datapath definitions: IR field slices, opcode constants, FSM states.
package inst_seq_ctrl_pkg;

    localparam logic [4:0] OP_MOVSGPR  = 5'd0;
    localparam logic [4:0] OP_MOV      = 5'd1;
    localparam logic [4:0] OP_ADD      = 5'd2;
    localparam logic [4:0] OP_SUB      = 5'd3;
    localparam logic [4:0] OP_MUL      = 5'd4;
    localparam logic [4:0] OP_JUMP     = 5'd16;
    localparam logic [4:0] OP_JCARRY   = 5'd17;
    localparam logic [4:0] OP_JNOCARRY = 5'd18;
    localparam logic [4:0] OP_JSIGN    = 5'd19;
    localparam logic [4:0] OP_JNOSIGN  = 5'd20;
    localparam logic [4:0] OP_JZERO    = 5'd21;
    localparam logic [4:0] OP_JNOZERO  = 5'd22;
    localparam logic [4:0] OP_JOVF     = 5'd23;
    localparam logic [4:0] OP_JNOOVF   = 5'd24;
    localparam logic [4:0] OP_HALT     = 5'd25;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DELAY = 3'd3,
        S_NEXT  = 3'd4,
        S_HALT  = 3'd5
    } seq_state_t;

    function automatic logic [4:0] oper_type(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] rdst(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic [4:0] rsrc1(input logic [31:0] ir);
        return ir[21:17];
    endfunction

    function automatic logic imm_mode(input logic [31:0] ir);
        return ir[16];
    endfunction

    function automatic logic [4:0] rsrc2(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] isrc(input logic [31:0] ir);
        return ir[15:0];
    endfunction

endpackage

// File: rtl/inst_seq_ctrl_if.sv
// Sequencer <-> instruction ROM / datapath bus; master is the sequencer side.
interface inst_seq_ctrl_if #(
    parameter int PC_W = 5,
    parameter int IR_W = 32
);
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic [IR_W-1:0] imem_data;
    logic            sign_f;
    logic            zero_f;
    logic            carry_f;
    logic            ovf_f;
    logic [IR_W-1:0] ir;
    logic            exec_en;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    modport master (
        input  start, imem_data, sign_f, zero_f, carry_f, ovf_f,
        output imem_addr, ir, exec_en, pc, busy, halted
    );

    modport slave (
        output start, imem_data, sign_f, zero_f, carry_f, ovf_f,
        input  imem_addr, ir, exec_en, pc, busy, halted
    );
endinterface

// File: rtl/jump_cond_eval.sv
// Combinational branch resolution: opcode + datapath flags -> taken, plus halt decode.
module jump_cond_eval
    import inst_seq_ctrl_pkg::*;
(
    input  logic [4:0] op,
    input  logic       sign_f,
    input  logic       zero_f,
    input  logic       carry_f,
    input  logic       ovf_f,
    output logic       taken,
    output logic       is_halt
);
    always_comb begin
        taken   = 1'b0;
        is_halt = 1'b0;
        case (op)
            OP_JUMP:     taken = 1'b1;
            OP_JCARRY:   taken = carry_f;
            OP_JNOCARRY: taken = ~carry_f;
            OP_JSIGN:    taken = sign_f;
            OP_JNOSIGN:  taken = ~sign_f;
            OP_JZERO:    taken = zero_f;
            OP_JNOZERO:  taken = ~zero_f;
            OP_JOVF:     taken = ovf_f;
            OP_JNOOVF:   taken = ~ovf_f;
            OP_HALT:     is_halt = 1'b1;
            default:     ;
        endcase
    end
endmodule

// File: rtl/inst_seq_ctrl.sv
// Multicycle instruction sequencer: FETCH -> EXEC -> DELAY -> NEXT per instruction.
// Define SEQ_DELAY_EN to stretch DELAY to DELAY_CYC cycles (minimum one).
module inst_seq_ctrl
    import inst_seq_ctrl_pkg::*;
#(
    parameter int PC_W      = 5,
    parameter int IR_W      = 32,
    parameter int DELAY_CYC = 4
) (
    input  logic              clk,
    input  logic              sys_rst,
    inst_seq_ctrl_if.master   bus
);
    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_q, next_pc;
    logic [IR_W-1:0] ir_q;
    logic            exec_q;
    logic            halt_pend;
    logic            taken, is_halt;
    logic            delay_done;

    jump_cond_eval u_jce (
        .op      (oper_type(ir_q[31:0])),
        .sign_f  (bus.sign_f),
        .zero_f  (bus.zero_f),
        .carry_f (bus.carry_f),
        .ovf_f   (bus.ovf_f),
        .taken   (taken),
        .is_halt (is_halt)
    );

`ifdef SEQ_DELAY_EN
    localparam int DLY_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = (DELAY_CYC == 0) ? '0 : DLY_W'(DELAY_CYC - 1);
    logic [DLY_W-1:0] dly_cnt;

    // Counter is reloaded while in EXEC so each DELAY phase starts from zero.
    always_ff @(posedge clk) begin
        if (sys_rst)
            dly_cnt <= '0;
        else if (state == S_DELAY && !delay_done)
            dly_cnt <= dly_cnt + 1'b1;
        else
            dly_cnt <= '0;
    end

    assign delay_done = (dly_cnt == DLY_LAST);
`else
    localparam int unused_delay_cyc = DELAY_CYC;
    assign delay_done = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DELAY;
            S_DELAY: if (delay_done) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = halt_pend ? S_HALT : S_FETCH;
            S_HALT:  if (bus.start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pc_q      <= '0;
            next_pc   <= '0;
            ir_q      <= '0;
            exec_q    <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            // Strobe is registered so it is high for exactly the EXEC cycle.
            exec_q <= (state_nxt == S_EXEC);
            case (state)
                S_FETCH: ir_q <= bus.imem_data;
                S_EXEC: begin
                    next_pc <= taken ? ir_q[PC_W-1:0] : pc_q + 1'b1;
                    if (is_halt) halt_pend <= 1'b1;
                end
                S_NEXT:  pc_q <= next_pc;
                S_HALT:  if (bus.start) halt_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.exec_en   = exec_q;
    assign bus.busy      = (state == S_FETCH) || (state == S_EXEC) ||
                           (state == S_DELAY) || (state == S_NEXT);
    assign bus.halted    = (state == S_HALT);
endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl (default build, 4 clk/instruction, PC_W=5).
module tb_inst_seq_ctrl;
    import inst_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] imem [32];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_exec = 0;

    inst_seq_ctrl_if #(.PC_W(5), .IR_W(32)) bus ();

    inst_seq_ctrl #(.PC_W(5), .IR_W(32), .DELAY_CYC(4)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.imem_data = imem[bus.imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] imm);
        return {op, 11'd0, imm};
    endfunction

    task automatic wait_exec(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.exec_en) seen = 1'b1;
        end
        if (!seen) chk("exec_timeout", 32'd0, 32'd1);
    endtask

    // Waits for the next strobe, checks pc/ir/spacing, then sets flags once EXEC has closed.
    task automatic step(input logic [4:0] exp_pc, input int exp_gap, input logic [3:0] nflags);
        logic seen;
        wait_exec(seen);
        if (seen) begin
            chk($sformatf("pc@%0d", exp_pc), 32'(bus.pc), 32'(exp_pc));
            chk($sformatf("ir@%0d", exp_pc), bus.ir, imem[exp_pc]);
            if (exp_gap != 0) chk($sformatf("gap@%0d", exp_pc), 32'(cyc - last_exec), 32'(exp_gap));
            last_exec = cyc;
            @(negedge clk);
            chk($sformatf("strobe_1cyc@%0d", exp_pc), 32'(bus.exec_en), 32'd0);
        end
        {bus.zero_f, bus.carry_f, bus.sign_f, bus.ovf_f} = nflags;
    endtask

    initial begin
        int strobes;
        logic seen;
        for (int i = 0; i < 32; i++) imem[i] = mk(OP_ADD, 16'(i + 16'h100));
        imem[4]  = mk(OP_JZERO, 16'd9);
        imem[9]  = mk(OP_JZERO, 16'd20);
        imem[10] = mk(OP_JNOCARRY, 16'd7);
        imem[11] = mk(OP_JNOOVF, 16'd7);
        imem[12] = mk(OP_JCARRY, 16'd7);
        imem[7]  = mk(OP_JUMP, 16'hFFE5);
        imem[5]  = mk(OP_JUMP, 16'd30);
        imem[30] = mk(OP_JNOSIGN, 16'd3);
        sys_rst = 1'b1;
        bus.start = 1'b0;
        {bus.zero_f, bus.carry_f, bus.sign_f, bus.ovf_f} = 4'b0000;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_ir", bus.ir, 32'd0);
        chk("rst_exec", 32'(bus.exec_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);

        // start held high while running: must be ignored while busy
        bus.start = 1'b1;
        step(5'd0, 0, 4'b0000);
        chk("busy_run", 32'(bus.busy), 32'd1);
        step(5'd1, 4, 4'b0000);
        step(5'd2, 4, 4'b0000);
        bus.start = 1'b0;
        step(5'd3, 4, 4'b1000);            // zero=1 for jzero 9
        step(5'd4, 4, 4'b0000);            // zero=0 for jzero 20
        step(5'd9, 4, 4'b0101);            // carry=1, ovf=1
        step(5'd10, 4, 4'b0101);
        step(5'd11, 4, 4'b0100);           // carry=1 for jcarry 7
        step(5'd12, 4, 4'b0000);
        step(5'd7, 4, 4'b0000);            // jump FFE5 -> 5
        step(5'd5, 4, 4'b0010);            // sign=1 for jnosign
        step(5'd30, 4, 4'b0000);
        imem[0] = mk(OP_HALT, 16'd0);
        step(5'd31, 4, 4'b0000);           // wraps to 0
        step(5'd0, 4, 4'b0000);            // halt

        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.exec_en) strobes++;
        end
        chk("halt_no_strobe", 32'(strobes), 32'd0);
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_pc", 32'(bus.pc), 32'd1);
        chk("halt_busy", 32'(bus.busy), 32'd0);

        imem[1] = mk(OP_JUMP, 16'd1);      // self loop
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("resume_halted", 32'(bus.halted), 32'd0);
        chk("resume_busy", 32'(bus.busy), 32'd1);
        step(5'd1, 0, 4'b0000);
        step(5'd1, 4, 4'b0000);

        // reset asserted while the strobe is high
        wait_exec(seen);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk("rstx_pc", 32'(bus.pc), 32'd0);
        chk("rstx_ir", bus.ir, 32'd0);
        chk("rstx_exec", 32'(bus.exec_en), 32'd0);
        chk("rstx_busy", 32'(bus.busy), 32'd0);
        chk("rstx_halted", 32'(bus.halted), 32'd0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.exec_en) strobes++;
        end
        chk("rstx_no_strobe", 32'(strobes), 32'd0);
        bus.start = 1'b1;
        step(5'd0, 0, 4'b0000);
        bus.start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
